// File: rtl/int_iq_dispatch_slot_allocator.sv
// Integer issue queue dispatch-side slot allocator: per-entry lifecycle
// tracking (free/valid/issued), dual-slot dispatch grants, issue handling,
// load-speculation hold window with replay on wake-up kill, and flush.
module int_iq_dispatch_slot_allocator #(
    parameter int unsigned IQ_NUM   = 8,
    parameter int unsigned IQ_WIDTH = 3,
    parameter int unsigned SPEC_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                disp_req0,
    input  logic                disp_req1,
    output logic                disp_stall,
    output logic [IQ_WIDTH-1:0] dispatch_slot_idx0,
    output logic [IQ_WIDTH-1:0] dispatch_slot_idx1,
    output logic                dispatch_instr0_valid,
    output logic                dispatch_instr1_valid,
    input  logic [IQ_WIDTH-1:0] issue_slot_idx0,
    input  logic [IQ_WIDTH-1:0] issue_slot_idx1,
    input  logic                issue_slot_idx0_valid,
    input  logic                issue_slot_idx1_valid,
    input  logic                issue_slot_idx0_is_poison,
    input  logic                issue_slot_idx1_is_poison,
    input  logic                load_wake_up_kill,
    input  logic                recovery_flush,
    output logic [IQ_NUM-1:0]   entry_valid,
    output logic [IQ_WIDTH:0]   free_count,
    output logic                alloc_err
);

    localparam int unsigned CNT_W = IQ_WIDTH + 1;
    localparam int unsigned TMR_W = 2;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_VALID  = 2'd1,
        ST_ISSUED = 2'd2
    } entry_state_e;

    entry_state_e     state_q [IQ_NUM];
    entry_state_e     state_d [IQ_NUM];
    logic [TMR_W-1:0] timer_q [IQ_NUM];
    logic [TMR_W-1:0] timer_d [IQ_NUM];
    logic [IQ_NUM-1:0] poison_q, poison_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic              alloc_err_q, alloc_err_d;

    logic [IQ_WIDTH-1:0] idx0_c, idx1_c;
    logic                found0_c, found1_c;
    logic                req0_c, req1_c;
    logic [CNT_W-1:0]    need_c;
    logic                stall_c, grant0_c, grant1_c;
    logic [IQ_NUM-1:0]   hit0_c, hit1_c, valid_c;

    // Pick the two lowest free slots from registered state and decide the atomic pair grant
    always_comb begin
        idx0_c   = '0;
        idx1_c   = '0;
        found0_c = 1'b0;
        found1_c = 1'b0;
        for (int i = 0; i < IQ_NUM; i++) begin
            if (state_q[i] == ST_FREE) begin
                if (!found0_c) begin
                    idx0_c   = IQ_WIDTH'(i);
                    found0_c = 1'b1;
                end else if (!found1_c) begin
                    idx1_c   = IQ_WIDTH'(i);
                    found1_c = 1'b1;
                end
            end
        end
        req0_c   = disp_req0;
        req1_c   = disp_req0 & disp_req1;
        need_c   = CNT_W'(req0_c) + CNT_W'(req1_c);
        stall_c  = need_c > free_count_q;
        grant0_c = req0_c & ~stall_c & ~recovery_flush;
        grant1_c = req1_c & ~stall_c & ~recovery_flush;
    end

    // Decode which entries each issue port names, and which entries are VALID
    always_comb begin
        hit0_c  = '0;
        hit1_c  = '0;
        valid_c = '0;
        for (int i = 0; i < IQ_NUM; i++) begin
            hit0_c[i]  = issue_slot_idx0_valid && (issue_slot_idx0 == IQ_WIDTH'(i));
            hit1_c[i]  = issue_slot_idx1_valid && (issue_slot_idx1 == IQ_WIDTH'(i));
            valid_c[i] = (state_q[i] == ST_VALID);
        end
    end

    // Per-entry next state, free count of the next state, sticky issue error
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        poison_d     = poison_q;
        free_count_d = '0;
        alloc_err_d  = alloc_err_q;
        if ((issue_slot_idx0_valid && ((hit0_c & valid_c) == '0)) ||
            (issue_slot_idx1_valid && ((hit1_c & valid_c) == '0))) begin
            alloc_err_d = 1'b1;
        end
        for (int i = 0; i < IQ_NUM; i++) begin
            case (state_q[i])
                ST_FREE: begin
                    if ((grant0_c && idx0_c == IQ_WIDTH'(i)) ||
                        (grant1_c && idx1_c == IQ_WIDTH'(i))) begin
                        state_d[i] = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (hit0_c[i] || hit1_c[i]) begin
                        state_d[i]  = ST_ISSUED;
                        timer_d[i]  = TMR_W'(SPEC_LAT);
                        poison_d[i] = (hit0_c[i] & issue_slot_idx0_is_poison) |
                                      (hit1_c[i] & issue_slot_idx1_is_poison);
                    end
                end
                ST_ISSUED: begin
                    // A kill on a poisoned entry beats timer expiry and re-arms it
                    if (poison_q[i] && load_wake_up_kill) begin
                        state_d[i]  = ST_VALID;
                        timer_d[i]  = '0;
                        poison_d[i] = 1'b0;
                    end else if (timer_q[i] == TMR_W'(1)) begin
                        state_d[i]  = ST_FREE;
                        timer_d[i]  = '0;
                        poison_d[i] = 1'b0;
                    end else begin
                        timer_d[i] = timer_q[i] - TMR_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_FREE;
                end
            endcase
            if (recovery_flush) begin
                state_d[i]  = ST_FREE;
                timer_d[i]  = '0;
                poison_d[i] = 1'b0;
            end
            if (state_d[i] == ST_FREE) begin
                free_count_d = free_count_d + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IQ_NUM; i++) begin
                state_q[i] <= ST_FREE;
                timer_q[i] <= '0;
            end
            poison_q     <= '0;
            free_count_q <= CNT_W'(IQ_NUM);
            alloc_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < IQ_NUM; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            poison_q     <= poison_d;
            free_count_q <= free_count_d;
            alloc_err_q  <= alloc_err_d;
        end
    end

    // Dispatch outputs are held at zero while reset is asserted
    assign disp_stall            = rst_n & stall_c;
    assign dispatch_slot_idx0    = rst_n ? idx0_c : '0;
    assign dispatch_slot_idx1    = rst_n ? idx1_c : '0;
    assign dispatch_instr0_valid = rst_n & grant0_c;
    assign dispatch_instr1_valid = rst_n & grant1_c;
    assign entry_valid           = valid_c;
    assign free_count            = free_count_q;
    assign alloc_err             = alloc_err_q;

endmodule
